// File: rtl/pipeline_exc_pkg.sv
// Shared types and constants for the multi-cycle EXC pipeline between EXA and MEM.
// exc_payload_t is the canonical default-width payload; the top re-derives it per XLEN/REGW.
package pipeline_exc_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int REGW_DEF  = 5;
  localparam int MAX_DEPTH = 8;

  localparam logic [2:0] DM_CTRL_NONE = 3'b000;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic                rf_wr_en;
    logic [1:0]          rf_wr_sel;
    logic [XLEN_DEF-1:0] alu_result;
    logic [2:0]          dm_rd_ctrl;
    logic [2:0]          dm_wr_ctrl;
    logic [XLEN_DEF-1:0] reg_data2;
    logic [REGW_DEF-1:0] rd;
  } exc_payload_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pipeline_exc_slot.sv
// One pipeline slot: a valid bit plus an opaque payload word.
// Clear drops only the valid bit; the payload may keep stale bits.
module pipeline_exc_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         clear,
  input  logic         valid_in,
  input  logic [W-1:0] payload_in,
  output logic         valid_out,
  output logic [W-1:0] payload_out
);

  logic         valid_q, valid_d;
  logic [W-1:0] payload_q, payload_d;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (!hold) begin
      valid_d   = valid_in;
      payload_d = payload_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_out   = valid_q;
  assign payload_out = payload_q;

endmodule

// File: rtl/pipeline_exc_stage_n.sv
// DEPTH-deep EXC pipeline for the mul/div path: shift/stall/flush slots,
// in-flight rd hazard detection and a registered occupancy count.
module pipeline_exc_stage_n
  import pipeline_exc_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 3,
  parameter int REGW  = REGW_DEF,
  parameter int OCCW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_EXA,
  input  logic [XLEN-1:0] pc_EXA,
  input  logic            rf_wr_en_EXA,
  input  logic [1:0]      rf_wr_sel_EXA,
  input  logic [XLEN-1:0] alu_result_EXA,
  input  logic [2:0]      dm_rd_ctrl_EXA,
  input  logic [2:0]      dm_wr_ctrl_EXA,
  input  logic [XLEN-1:0] reg_data2_EXA,
  input  logic [REGW-1:0] rd_EXA,
  input  logic [REGW-1:0] rs1_ID,
  input  logic [REGW-1:0] rs2_ID,
  output logic            valid_EXC,
  output logic [XLEN-1:0] pc_EXC,
  output logic            rf_wr_en_EXC,
  output logic [1:0]      rf_wr_sel_EXC,
  output logic [XLEN-1:0] alu_result_EXC,
  output logic [2:0]      dm_rd_ctrl_EXC,
  output logic [2:0]      dm_wr_ctrl_EXC,
  output logic [XLEN-1:0] reg_data2_EXC,
  output logic [REGW-1:0] rd_EXC,
  output logic            hazard_rs1,
  output logic            hazard_rs2,
  output logic [OCCW-1:0] occupancy,
  output logic            busy
);

  generate
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("pipeline_exc_stage_n: DEPTH must be in 1..8");
    end
  endgenerate

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            rf_wr_en;
    logic [1:0]      rf_wr_sel;
    logic [XLEN-1:0] alu_result;
    logic [2:0]      dm_rd_ctrl;
    logic [2:0]      dm_wr_ctrl;
    logic [XLEN-1:0] reg_data2;
    logic [REGW-1:0] rd;
  } slot_t;

  localparam int PW = $bits(slot_t);

  slot_t            exa_payload;
  slot_t            payload_s [DEPTH];
  logic [DEPTH-1:0] valid_vec;

  assign exa_payload = '{pc: pc_EXA, rf_wr_en: rf_wr_en_EXA, rf_wr_sel: rf_wr_sel_EXA,
                         alu_result: alu_result_EXA, dm_rd_ctrl: dm_rd_ctrl_EXA,
                         dm_wr_ctrl: dm_wr_ctrl_EXA, reg_data2: reg_data2_EXA, rd: rd_EXA};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic          valid_in;
      logic [PW-1:0] payload_in;
      logic [PW-1:0] payload_out;

      if (gi == 0) begin : g_head
        assign valid_in   = valid_EXA;
        assign payload_in = exa_payload;
      end else begin : g_body
        assign valid_in   = valid_vec[gi-1];
        assign payload_in = payload_s[gi-1];
      end

      pipeline_exc_slot #(.W(PW)) u_slot (
        .clk        (clk),
        .reset      (reset),
        .hold       (stall),
        .clear      (flush),
        .valid_in   (valid_in),
        .payload_in (payload_in),
        .valid_out  (valid_vec[gi]),
        .payload_out(payload_out)
      );

      assign payload_s[gi] = slot_t'(payload_out);
    end
  endgenerate

  // Mirror of the slot update rule, used only to precompute the next count.
  logic [DEPTH:0]   valid_shift;
  logic [DEPTH-1:0] valid_next;
  logic [7:0]       valid_pad;
  logic [OCCW-1:0]  occupancy_q, occupancy_d;

  always_comb begin
    valid_shift = {valid_vec, valid_EXA};
    if (flush) begin
      valid_next = '0;
    end else if (stall) begin
      valid_next = valid_vec;
    end else begin
      valid_next = valid_shift[DEPTH-1:0];
    end
    valid_pad              = '0;
    valid_pad[DEPTH-1:0]   = valid_next;
    occupancy_d            = OCCW'(popcount8(valid_pad));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign occupancy = occupancy_q;
  assign busy      = (occupancy_q != '0);

  always_comb begin
    hazard_rs1 = 1'b0;
    hazard_rs2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_vec[k] && payload_s[k].rf_wr_en && (payload_s[k].rd == rs1_ID)) begin
        hazard_rs1 = 1'b1;
      end
      if (valid_vec[k] && payload_s[k].rf_wr_en && (payload_s[k].rd == rs2_ID)) begin
        hazard_rs2 = 1'b1;
      end
    end
    hazard_rs1 = hazard_rs1 && (rs1_ID != '0);
    hazard_rs2 = hazard_rs2 && (rs2_ID != '0);
  end

  assign valid_EXC      = valid_vec[DEPTH-1];
  assign pc_EXC         = payload_s[DEPTH-1].pc;
  assign rf_wr_en_EXC   = payload_s[DEPTH-1].rf_wr_en & valid_EXC;
  assign rf_wr_sel_EXC  = payload_s[DEPTH-1].rf_wr_sel;
  assign alu_result_EXC = payload_s[DEPTH-1].alu_result;
  assign dm_rd_ctrl_EXC = valid_EXC ? payload_s[DEPTH-1].dm_rd_ctrl : DM_CTRL_NONE;
  assign dm_wr_ctrl_EXC = valid_EXC ? payload_s[DEPTH-1].dm_wr_ctrl : DM_CTRL_NONE;
  assign reg_data2_EXC  = payload_s[DEPTH-1].reg_data2;
  assign rd_EXC         = payload_s[DEPTH-1].rd;

endmodule

// File: tb/tb_pipeline_exc_stage_n.sv
// Directed bench: DEPTH=3 instance for latency/stall/flush/hazard/reset,
// DEPTH=1 instance for bubble qualification.
module tb_pipeline_exc_stage_n;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // DEPTH=3 instance signals
  logic        stall, flush, valid_EXA, rf_wr_en_EXA;
  logic [63:0] pc_EXA, alu_result_EXA, reg_data2_EXA;
  logic [1:0]  rf_wr_sel_EXA;
  logic [2:0]  dm_rd_ctrl_EXA, dm_wr_ctrl_EXA;
  logic [4:0]  rd_EXA, rs1_ID, rs2_ID;
  logic        valid_EXC, rf_wr_en_EXC, hazard_rs1, hazard_rs2, busy;
  logic [63:0] pc_EXC, alu_result_EXC, reg_data2_EXC;
  logic [1:0]  rf_wr_sel_EXC;
  logic [2:0]  dm_rd_ctrl_EXC, dm_wr_ctrl_EXC;
  logic [4:0]  rd_EXC;
  logic [1:0]  occupancy;

  // DEPTH=1 instance signals
  logic        v1_in, wr1_in;
  logic [63:0] pc1_in;
  logic [2:0]  dmw1_in;
  logic        v1_out, wr1_out, h1a, h1b, busy1;
  logic [63:0] pc1_out, alu1_out, rd2_1_out;
  logic [1:0]  sel1_out;
  logic [2:0]  dmr1_out, dmw1_out;
  logic [4:0]  rd1_out;
  logic [0:0]  occ1;

  pipeline_exc_stage_n #(.DEPTH(3)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_EXA(valid_EXA), .pc_EXA(pc_EXA), .rf_wr_en_EXA(rf_wr_en_EXA),
    .rf_wr_sel_EXA(rf_wr_sel_EXA), .alu_result_EXA(alu_result_EXA),
    .dm_rd_ctrl_EXA(dm_rd_ctrl_EXA), .dm_wr_ctrl_EXA(dm_wr_ctrl_EXA),
    .reg_data2_EXA(reg_data2_EXA), .rd_EXA(rd_EXA), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .valid_EXC(valid_EXC), .pc_EXC(pc_EXC), .rf_wr_en_EXC(rf_wr_en_EXC),
    .rf_wr_sel_EXC(rf_wr_sel_EXC), .alu_result_EXC(alu_result_EXC),
    .dm_rd_ctrl_EXC(dm_rd_ctrl_EXC), .dm_wr_ctrl_EXC(dm_wr_ctrl_EXC),
    .reg_data2_EXC(reg_data2_EXC), .rd_EXC(rd_EXC), .hazard_rs1(hazard_rs1),
    .hazard_rs2(hazard_rs2), .occupancy(occupancy), .busy(busy)
  );

  pipeline_exc_stage_n #(.DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0),
    .valid_EXA(v1_in), .pc_EXA(pc1_in), .rf_wr_en_EXA(wr1_in),
    .rf_wr_sel_EXA(2'b01), .alu_result_EXA(64'h0),
    .dm_rd_ctrl_EXA(3'b000), .dm_wr_ctrl_EXA(dmw1_in),
    .reg_data2_EXA(64'h0), .rd_EXA(5'd3), .rs1_ID(5'd0), .rs2_ID(5'd0),
    .valid_EXC(v1_out), .pc_EXC(pc1_out), .rf_wr_en_EXC(wr1_out),
    .rf_wr_sel_EXC(sel1_out), .alu_result_EXC(alu1_out),
    .dm_rd_ctrl_EXC(dmr1_out), .dm_wr_ctrl_EXC(dmw1_out),
    .reg_data2_EXC(rd2_1_out), .rd_EXC(rd1_out), .hazard_rs1(h1a),
    .hazard_rs2(h1b), .occupancy(occ1), .busy(busy1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-16s obs=0x%0h exp=0x%0h ok", tag, obs, exp);
    end else begin
      $display("FAIL %-16s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic wr,
                       input logic [4:0] rd, input logic [2:0] dmw);
    valid_EXA      = v;
    pc_EXA         = pc;
    rf_wr_en_EXA   = wr;
    rd_EXA         = rd;
    dm_wr_ctrl_EXA = dmw;
    alu_result_EXA = pc + 64'h1000;
    reg_data2_EXA  = pc + 64'h2000;
  endtask

  task automatic bubble();
    drive(1'b0, 64'h0, 1'b0, 5'd0, 3'b000);
  endtask

  initial begin
    stall = 0; flush = 0; rf_wr_sel_EXA = 2'b10; dm_rd_ctrl_EXA = 3'b000;
    rs1_ID = 0; rs2_ID = 0;
    bubble();
    v1_in = 0; wr1_in = 1; pc1_in = 0; dmw1_in = 3'b011;
    #12;
    check_eq("rst_occ", 64'(occupancy), 64'd0);
    check_eq("rst_valid", 64'(valid_EXC), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    check_eq("rel_occ", 64'(occupancy), 64'd0);

    // latency
    drive(1'b1, 64'h100, 1'b1, 5'd5, 3'b000);
    tick(); bubble();
    check_eq("lat_occ1", 64'(occupancy), 64'd1);
    check_eq("lat_valid1", 64'(valid_EXC), 64'd0);
    tick();
    check_eq("lat_occ2", 64'(occupancy), 64'd1);
    tick();
    check_eq("lat_pc", pc_EXC, 64'h100);
    check_eq("lat_wren", 64'(rf_wr_en_EXC), 64'd1);
    check_eq("lat_rd", 64'(rd_EXC), 64'd5);
    check_eq("lat_alu", alu_result_EXC, 64'h1100);
    tick();
    check_eq("drain_occ", 64'(occupancy), 64'd0);
    check_eq("drain_wren", 64'(rf_wr_en_EXC), 64'd0);
    check_eq("drain_busy", 64'(busy), 64'd0);

    // hazard
    drive(1'b1, 64'h200, 1'b1, 5'd7, 3'b000);
    tick(); bubble(); tick();
    rs1_ID = 7; rs2_ID = 0; #1;
    check_eq("haz_rs1", 64'(hazard_rs1), 64'd1);
    check_eq("haz_rs2_zero", 64'(hazard_rs2), 64'd0);
    rs2_ID = 7; #1;
    check_eq("haz_rs2", 64'(hazard_rs2), 64'd1);
    rs2_ID = 6; #1;
    check_eq("haz_rs2_miss", 64'(hazard_rs2), 64'd0);
    flush = 1; tick(); flush = 0;
    check_eq("haz_flush_occ", 64'(occupancy), 64'd0);
    check_eq("haz_flush_h1", 64'(hazard_rs1), 64'd0);
    drive(1'b1, 64'h210, 1'b1, 5'd0, 3'b000);
    tick(); bubble(); tick();
    rs1_ID = 0; rs2_ID = 7; #1;
    check_eq("haz_rd0_rs1", 64'(hazard_rs1), 64'd0);
    check_eq("haz_rd0_rs2", 64'(hazard_rs2), 64'd0);
    flush = 1; tick(); flush = 0;
    drive(1'b1, 64'h220, 1'b0, 5'd7, 3'b000);
    tick(); bubble(); tick();
    rs1_ID = 7; rs2_ID = 7; #1;
    check_eq("haz_nowr_rs1", 64'(hazard_rs1), 64'd0);
    check_eq("haz_nowr_rs2", 64'(hazard_rs2), 64'd0);
    rs1_ID = 0; rs2_ID = 0;
    flush = 1; tick(); flush = 0;

    // stall
    drive(1'b1, 64'h300, 1'b1, 5'd1, 3'b000); tick();
    drive(1'b1, 64'h304, 1'b1, 5'd2, 3'b000); tick();
    check_eq("stl_occ_pre", 64'(occupancy), 64'd2);
    stall = 1; drive(1'b1, 64'hdead, 1'b1, 5'd9, 3'b000);
    tick();
    check_eq("stl_occ_a", 64'(occupancy), 64'd2);
    check_eq("stl_valid_a", 64'(valid_EXC), 64'd0);
    tick();
    check_eq("stl_occ_b", 64'(occupancy), 64'd2);
    check_eq("stl_busy", 64'(busy), 64'd1);
    stall = 0; bubble();
    tick();
    check_eq("stl_out1_pc", pc_EXC, 64'h300);
    check_eq("stl_out1_rd", 64'(rd_EXC), 64'd1);
    check_eq("stl_out1_v", 64'(valid_EXC), 64'd1);
    tick();
    check_eq("stl_out2_pc", pc_EXC, 64'h304);
    check_eq("stl_occ_c", 64'(occupancy), 64'd1);
    tick();
    check_eq("stl_end_v", 64'(valid_EXC), 64'd0);
    check_eq("stl_end_occ", 64'(occupancy), 64'd0);

    // flush beats stall and incoming entry
    drive(1'b1, 64'h400, 1'b1, 5'd4, 3'b011); tick();
    drive(1'b1, 64'h404, 1'b1, 5'd4, 3'b011); tick();
    drive(1'b1, 64'h408, 1'b1, 5'd4, 3'b011); tick();
    check_eq("fl_pre_dmw", 64'(dm_wr_ctrl_EXC), 64'd3);
    check_eq("fl_pre_occ", 64'(occupancy), 64'd3);
    stall = 1; flush = 1;
    drive(1'b1, 64'h500, 1'b1, 5'd4, 3'b011);
    tick();
    stall = 0; flush = 0; bubble();
    check_eq("fl_occ", 64'(occupancy), 64'd0);
    check_eq("fl_valid", 64'(valid_EXC), 64'd0);
    check_eq("fl_dmw", 64'(dm_wr_ctrl_EXC), 64'd0);
    check_eq("fl_wren", 64'(rf_wr_en_EXC), 64'd0);
    tick(); tick();
    check_eq("fl_discard_v", 64'(valid_EXC), 64'd0);
    check_eq("fl_discard_occ", 64'(occupancy), 64'd0);

    // async reset mid-stream
    drive(1'b1, 64'h600, 1'b1, 5'd9, 3'b000); tick();
    drive(1'b1, 64'h604, 1'b1, 5'd9, 3'b000); tick();
    drive(1'b1, 64'h608, 1'b1, 5'd9, 3'b000); tick();
    rs1_ID = 9; #1;
    check_eq("rs_pre_occ", 64'(occupancy), 64'd3);
    check_eq("rs_pre_haz", 64'(hazard_rs1), 64'd1);
    #1 reset = 1'b0;
    #1;
    check_eq("rs_pc", pc_EXC, 64'h0);
    check_eq("rs_valid", 64'(valid_EXC), 64'd0);
    check_eq("rs_occ", 64'(occupancy), 64'd0);
    check_eq("rs_busy", 64'(busy), 64'd0);
    check_eq("rs_haz", 64'(hazard_rs1), 64'd0);
    check_eq("rs_wren", 64'(rf_wr_en_EXC), 64'd0);
    bubble(); rs1_ID = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    check_eq("rs_rel_occ", 64'(occupancy), 64'd0);

    // DEPTH=1 bubbles
    for (int i = 0; i < 6; i++) begin
      v1_in  = (i % 2 == 0);
      pc1_in = 64'h700 + 64'(i);
      tick();
      check_eq("d1_dmw", 64'(dmw1_out), (i % 2 == 0) ? 64'd3 : 64'd0);
      check_eq("d1_wren", 64'(wr1_out), (i % 2 == 0) ? 64'd1 : 64'd0);
      check_eq("d1_pc", pc1_out, 64'h700 + 64'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
